sn_width_adapter: RTL and testbench
===================================

SN_WIDTH_ADAPTER -- requirements
Module: sn_width_adapter

Interface
REQ-001 SHALL have parameter PACKMEM_ADDR_WIDTH, default 8, packet-memory word address width.
REQ-002 SHALL have parameter PACKMEM_DATA_WIDTH, default 64, packet-memory word width.
REQ-003 SHALL have parameter SN_DATA_WIDTH, default 32, snooper beat width; PACKMEM_DATA_WIDTH = RATIO*SN_DATA_WIDTH, RATIO a power of two, 1..8.
REQ-004 SHALL have parameter INC_WIDTH, default 8, byte-increment width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 sn_wr_data  in  SN_DATA_WIDTH  snooper beat data.
REQ-009 sn_wr_en  in  1  beat valid.
REQ-010 sn_byte_inc  in  INC_WIDTH  valid bytes in this beat.
REQ-011 sn_done  in  1  packet end, single-cycle pulse.
REQ-012 rdy_for_sn_ack  in  1  snooper accepts buffer.
REQ-013 rdy_for_sn  out  1  buffer available to snooper.
REQ-014 addr  out  PACKMEM_ADDR_WIDTH+1  write address, LSB always 0.
REQ-015 wr_en / wr_data / byte_inc  out  1 / PACKMEM_DATA_WIDTH / INC_WIDTH  packed word write.
REQ-016 done / rdy_ack  out  1 / 1  packet complete; buffer claimed.
REQ-017 rdy  in  1  P3 system has a free buffer.

Function
REQ-018 SHALL implement states IDLE, FILL, FLUSH, DONE.
REQ-019 IDLE: rdy_for_sn = rdy; rdy_ack = rdy_for_sn_ack & rdy; on rdy_ack go to FILL with word address 0, lane count 0, byte accumulator 0.
REQ-020 In all states other than IDLE, rdy_for_sn and rdy_ack SHALL be 0.
REQ-021 FILL: each sn_wr_en beat SHALL be stored in lane (RATIO-1-lane count), first beat in MS lane; sn_byte_inc added to accumulator, accumulator width INC_WIDTH, modulo 2^INC_WIDTH.
REQ-022 When the RATIO-th beat is taken, next cycle SHALL drive wr_en=1 for one cycle with packed word, addr={word address,1'b0}, byte_inc=accumulator; word address then increments, lane count and accumulator clear.
REQ-023 Beats arriving in the cycle wr_en is driven SHALL be accepted into the next word without loss (back-to-back, one beat per cycle sustained).
REQ-024 sn_done in FILL (beat in same cycle included) SHALL go to FLUSH if lane count>0 after that beat, else to DONE.
REQ-025 FLUSH: one-cycle write of partial word, unfilled lanes zero, byte_inc=accumulator; then DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 sn_wr_en or sn_done outside FILL SHALL be ignored.
REQ-028 Without the configuration macro, word address SHALL wrap from 2^PACKMEM_ADDR_WIDTH-1 to 0.
REQ-029 wr_en, wr_data, addr, byte_inc, done SHALL be registered outputs.

Reset
REQ-030 On rst low, all state SHALL clear immediately: state IDLE, wr_en=0, done=0, addr=0, wr_data=0, byte_inc=0, counters 0.
REQ-031 Reset mid-packet SHALL discard the partial word; no write and no done pulse result.

Configuration
REQ-032 Macro SN_WIDTH_ADAPTER_ADDR_GUARD_EN: when defined, after the write to the last word address further full-word and flush writes SHALL be suppressed until DONE; done still pulses.
REQ-033 When not defined, REQ-028 wrap applies and every word is written.

Verification
REQ-034 RATIO=2: rdy=1, ack, beats 0xAAAA0001 inc 4, 0xBBBB0002 inc 4 -> wr_en next cycle, wr_data=0xAAAA0001BBBB0002, addr=0, byte_inc=8.
REQ-035 RATIO=2: 5 back-to-back beats inc 4, sn_done with 5th -> writes at addr 0,2 (byte_inc 8), flush at addr 4 with low lane 0, byte_inc 4, done one cycle after.
REQ-036 sn_done with no beats in current word after full write -> no flush, done one cycle later.
REQ-037 PACKMEM_ADDR_WIDTH=2, 10 full words: without macro addr sequence 0,2,4,6,0,2,...; with macro only 4 writes, done still pulses.
REQ-038 rst low after 1 beat of a word -> outputs 0 immediately, no write, state IDLE; rdy_for_sn follows rdy.
REQ-039 rdy=0 with rdy_for_sn_ack=1 -> rdy_ack=0, stays IDLE, beats ignored.

Source files
------------

// File: rtl/sn_width_adapter_if.sv
// Snooper-side and packet-memory-side signals of sn_width_adapter.
// master = the adapter's view, slave = the snooper / packet-memory side.
interface sn_width_adapter_if #(
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int SN_DATA_WIDTH      = 32,
  parameter int INC_WIDTH          = 8
);
  logic [SN_DATA_WIDTH-1:0]      sn_wr_data;
  logic                          sn_wr_en;
  logic [INC_WIDTH-1:0]          sn_byte_inc;
  logic                          sn_done;
  logic                          rdy_for_sn_ack;
  logic                          rdy_for_sn;
  logic [PACKMEM_ADDR_WIDTH:0]   addr;
  logic                          wr_en;
  logic [PACKMEM_DATA_WIDTH-1:0] wr_data;
  logic [INC_WIDTH-1:0]          byte_inc;
  logic                          done;
  logic                          rdy_ack;
  logic                          rdy;

  modport master (
    input  sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack, rdy,
    output rdy_for_sn, addr, wr_en, wr_data, byte_inc, done, rdy_ack
  );

  modport slave (
    output sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack, rdy,
    input  rdy_for_sn, addr, wr_en, wr_data, byte_inc, done, rdy_ack
  );
endinterface

// File: rtl/sn_width_adapter.sv
// Packs narrow snooper beats (first beat in the MS lane) into packet-memory words.
// Optional macro SN_WIDTH_ADAPTER_ADDR_GUARD_EN: stop writing once the last word address is used.

module sn_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
endmodule

module sn_width_adapter #(
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int SN_DATA_WIDTH      = 32,
  parameter int INC_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sn_width_adapter_if.master   bus
);
  localparam int RATIO = PACKMEM_DATA_WIDTH / SN_DATA_WIDTH;
  localparam int LCW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                              state;
  logic [PACKMEM_ADDR_WIDTH-1:0]           waddr;
  logic [LCW-1:0]                          cnt;
  logic [INC_WIDTH-1:0]                    acc, acc_nxt;
  logic [RATIO-1:0][SN_DATA_WIDTH-1:0]     lane_q, lane_nxt;
  logic [RATIO-1:0]                        lane_ld;
  logic                                    claim, beat, last_beat, lane_clr, wr_allow;

  logic                                    wr_en_q, done_q;
  logic [PACKMEM_ADDR_WIDTH:0]             addr_q;
  logic [PACKMEM_DATA_WIDTH-1:0]           wr_data_q;
  logic [INC_WIDTH-1:0]                    byte_inc_q;

  assign claim     = (state == S_IDLE) & bus.rdy & bus.rdy_for_sn_ack;
  assign beat      = (state == S_FILL) & bus.sn_wr_en;
  assign last_beat = beat & (int'(cnt) == RATIO - 1);
  assign acc_nxt   = acc + bus.sn_byte_inc;
  // lanes are emptied whenever a word leaves, so a flush naturally zero-fills
  assign lane_clr  = claim | last_beat | (state == S_FLUSH);

  assign bus.rdy_for_sn = (state == S_IDLE) & bus.rdy;
  assign bus.rdy_ack    = claim;
  assign bus.wr_en      = wr_en_q;
  assign bus.done       = done_q;
  assign bus.addr       = addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.byte_inc   = byte_inc_q;

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign lane_ld[i]  = beat & (int'(cnt) == RATIO - 1 - i);
    assign lane_nxt[i] = lane_ld[i] ? bus.sn_wr_data : lane_q[i];
    sn_lane #(.W(SN_DATA_WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .ld  (lane_ld[i]),
      .clr (lane_clr),
      .d   (bus.sn_wr_data),
      .q   (lane_q[i])
    );
  end

`ifdef SN_WIDTH_ADAPTER_ADDR_GUARD_EN
  logic guard_full;
  assign wr_allow = ~guard_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst)                                  guard_full <= 1'b0;
    else if (state == S_DONE)                  guard_full <= 1'b0;
    else if (wr_allow && last_beat && &waddr)  guard_full <= 1'b1;
`else
  assign wr_allow = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      waddr      <= '0;
      cnt        <= '0;
      acc        <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      byte_inc_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: if (claim) begin
          state <= S_FILL;
          waddr <= '0;
          cnt   <= '0;
          acc   <= '0;
        end
        S_FILL: begin
          if (last_beat) begin
            cnt   <= '0;
            acc   <= '0;
            waddr <= waddr + 1'b1;
            if (wr_allow) begin
              wr_en_q    <= 1'b1;
              wr_data_q  <= lane_nxt;
              addr_q     <= {waddr, 1'b0};
              byte_inc_q <= acc_nxt;
            end
          end else if (beat) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
          end
          // lane count after this cycle's beat decides whether a partial word remains
          if (bus.sn_done)
            state <= (beat ? !last_beat : (cnt != '0)) ? S_FLUSH : S_DONE;
        end
        S_FLUSH: begin
          state <= S_DONE;
          cnt   <= '0;
          acc   <= '0;
          if (wr_allow) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= lane_q;
            addr_q     <= {waddr, 1'b0};
            byte_inc_q <= acc;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sn_width_adapter.sv
// Randomized bench for sn_width_adapter (RATIO=2, 4-word packet memory) against a packet-level model.
module tb_sn_width_adapter;
  localparam int AW  = 2;
  localparam int DW  = 64;
  localparam int SW  = 32;
  localparam int IW  = 8;
  localparam int R   = DW / SW;
  localparam int AWP = AW + 1;
  localparam int NWORDS = 1 << AW;
`ifdef SN_WIDTH_ADAPTER_ADDR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [AW:0]   a;
    logic [DW-1:0] d;
    logic [IW-1:0] b;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sn_width_adapter_if #(.PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW),
                        .SN_DATA_WIDTH(SW), .INC_WIDTH(IW)) bus ();

  sn_width_adapter #(.PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW),
                     .SN_DATA_WIDTH(SW), .INC_WIDTH(IW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_nw;
  wr_t obs_q[$], exp_q[$];
  int  obs_cyc[$], done_cyc[$];
  logic [SW-1:0] beat_d[$];
  logic [IW-1:0] beat_i[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en === 1'b1) begin
      obs_q.push_back('{bus.addr, bus.wr_data, bus.byte_inc});
      obs_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
  end

  // Packet model: beats grouped RATIO at a time, first beat most significant.
  function automatic void build_exp();
    wr_t e;
    exp_q.delete();
    exp_nw = (beat_d.size() + R - 1) / R;
    for (int w = 0; w < exp_nw; w++) begin
      e = '0;
      for (int l = 0; l < R; l++) begin
        int k = w * R + l;
        if (k < beat_d.size()) begin
          e.d[(R-1-l)*SW +: SW] = beat_d[k];
          e.b = e.b + beat_i[k];
        end
      end
      e.a = AWP'((w % NWORDS) * 2);
      if (!(GUARD && w >= NWORDS)) exp_q.push_back(e);
    end
  endfunction

  task automatic clear_obs();
    beat_d.delete(); beat_i.delete();
    obs_q.delete(); obs_cyc.delete(); done_cyc.delete();
  endtask

  task automatic run_packet(input string tag, input int n, input int gap_max,
                            input bit dwl, input bit inc4);
    int t;
    clear_obs();
    @(negedge clk);
    bus.rdy = 1'b1; bus.rdy_for_sn_ack = 1'b1;
    #1;
    total++;
    if (bus.rdy_ack !== 1'b1) begin
      bad++; $display("FAIL %s claim: rdy_ack=%b want 1", tag, bus.rdy_ack);
    end
    @(negedge clk);
    bus.rdy_for_sn_ack = 1'b1;
    #1;
    total++;
    if (bus.rdy_for_sn !== 1'b0 || bus.rdy_ack !== 1'b0) begin
      bad++; $display("FAIL %s busy handshake: rdy_for_sn=%b rdy_ack=%b want 0 0", tag, bus.rdy_for_sn, bus.rdy_ack);
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      bus.sn_wr_en    = 1'b1;
      bus.sn_wr_data  = $urandom;
      bus.sn_byte_inc = inc4 ? IW'(4) : IW'($urandom_range(0, 255));
      bus.sn_done     = dwl && (k == n - 1);
      beat_d.push_back(bus.sn_wr_data);
      beat_i.push_back(bus.sn_byte_inc);
      @(negedge clk);
      bus.sn_wr_en = 1'b0; bus.sn_done = 1'b0; bus.rdy_for_sn_ack = 1'b0;
    end
    bus.rdy_for_sn_ack = 1'b0;
    if (!dwl) begin
      bus.sn_done = 1'b1;
      @(negedge clk);
      bus.sn_done = 1'b0;
    end
    t = 0;
    while (done_cyc.size() == 0 && t < 30) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    bus.rdy = 1'b0;
    build_exp();
    total++;
    if (done_cyc.size() != 1) begin
      bad++; $display("FAIL %s done pulses: got %0d want 1", tag, done_cyc.size());
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s write count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s write %0d: got addr=%0h data=%h inc=%0d want addr=%0h data=%h inc=%0d",
                   tag, i, obs_q[i].a, obs_q[i].d, obs_q[i].b, exp_q[i].a, exp_q[i].d, exp_q[i].b);
        end
      end
    end
    if (dwl && exp_q.size() == exp_nw && exp_nw > 0 && obs_cyc.size() > 0 && done_cyc.size() > 0) begin
      total++;
      if (done_cyc[0] !== obs_cyc[obs_cyc.size()-1] + 1) begin
        bad++; $display("FAIL %s done timing: done at %0d want %0d", tag, done_cyc[0], obs_cyc[obs_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rdy = 1'b1;
    #1;
    total++;
    if ({bus.wr_en, bus.done, bus.addr, bus.wr_data, bus.byte_inc} !== '0) begin
      bad++; $display("FAIL reset outputs: wr_en=%b done=%b addr=%0h data=%h inc=%0d want all 0",
                      bus.wr_en, bus.done, bus.addr, bus.wr_data, bus.byte_inc);
    end
    total++;
    if (bus.rdy_for_sn !== 1'b1) begin bad++; $display("FAIL reset rdy_for_sn: got %b want 1", bus.rdy_for_sn); end
    bus.rdy = 1'b0;
    #1;
    total++;
    if (bus.rdy_for_sn !== 1'b0) begin bad++; $display("FAIL reset rdy_for_sn low: got %b want 0", bus.rdy_for_sn); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] want_d;
    want_d = 64'hAAAA0001BBBB0002;
    clear_obs();
    @(negedge clk); bus.rdy = 1'b1; bus.rdy_for_sn_ack = 1'b1;
    @(negedge clk); bus.rdy_for_sn_ack = 1'b0;
    bus.sn_wr_en = 1'b1; bus.sn_wr_data = 32'hAAAA0001; bus.sn_byte_inc = 8'd4;
    @(negedge clk); bus.sn_wr_data = 32'hBBBB0002;
    @(negedge clk); bus.sn_wr_en = 1'b0;
    #1;
    total++;
    if (bus.wr_en !== 1'b1 || bus.wr_data !== want_d || bus.addr !== '0 || bus.byte_inc !== 8'd8) begin
      bad++; $display("FAIL basic word: wr_en=%b data=%h addr=%0h inc=%0d want 1 %h 0 8",
                      bus.wr_en, bus.wr_data, bus.addr, bus.byte_inc, want_d);
    end
    @(negedge clk); bus.sn_done = 1'b1;
    #1;
    total++;
    if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL basic single-cycle wr_en: got %b want 0", bus.wr_en); end
    @(negedge clk); bus.sn_done = 1'b0;
    repeat (4) @(negedge clk);
    bus.rdy = 1'b0;
    total++;
    if (done_cyc.size() != 1 || obs_q.size() != 1) begin
      bad++; $display("FAIL basic totals: done=%0d writes=%0d want 1 1", done_cyc.size(), obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    run_packet("b2b5", 5, 0, 1'b1, 1'b1);
    if (obs_q.size() == 3) begin
      total++;
      if (obs_q[2].d[SW-1:0] !== '0 || obs_q[2].b !== 8'd4 || obs_q[2].a !== 3'd4) begin
        bad++; $display("FAIL b2b5 flush: low=%h inc=%0d addr=%0h want 0 4 4", obs_q[2].d[SW-1:0], obs_q[2].b, obs_q[2].a);
      end
    end
    run_packet("b2b_rand", 7, 0, 1'b1, 1'b0);
  endtask

  task automatic test_no_flush();
    run_packet("noflush_sep", 4, 0, 1'b0, 1'b1);
    run_packet("noflush_same", 4, 0, 1'b1, 1'b1);
    run_packet("empty", 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    run_packet("wrap10", 20, 0, 1'b1, 1'b0);
    run_packet("wrap_flush", 19, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    @(negedge clk); bus.rdy = 1'b1; bus.rdy_for_sn_ack = 1'b1;
    @(negedge clk); bus.rdy_for_sn_ack = 1'b0;
    bus.sn_wr_en = 1'b1; bus.sn_byte_inc = 8'd3; bus.sn_wr_data = $urandom;
    @(negedge clk); bus.sn_wr_data = $urandom;
    @(negedge clk); bus.sn_wr_data = $urandom;
    #1;
    total++;
    if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL rstmid pre-write: wr_en=%b want 1", bus.wr_en); end
    @(posedge clk); #2;
    bus.sn_wr_en = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.wr_en, bus.done, bus.addr, bus.wr_data, bus.byte_inc} !== '0) begin
      bad++; $display("FAIL rstmid outputs: wr_en=%b done=%b addr=%0h data=%h inc=%0d want all 0",
                      bus.wr_en, bus.done, bus.addr, bus.wr_data, bus.byte_inc);
    end
    total++;
    if (bus.rdy_for_sn !== 1'b1) begin bad++; $display("FAIL rstmid rdy_for_sn: got %b want 1", bus.rdy_for_sn); end
    @(negedge clk); @(negedge clk); rst = 1'b1;
    bus.rdy = 1'b0;
    bus.sn_wr_en = 1'b1; bus.sn_done = 1'b1;
    repeat (4) @(negedge clk);
    bus.sn_wr_en = 1'b0; bus.sn_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_q.size() != 1 || done_cyc.size() != 0) begin
      bad++; $display("FAIL rstmid aftermath: writes=%0d done=%0d want 1 0", obs_q.size(), done_cyc.size());
    end
  endtask

  task automatic test_rdy_low();
    clear_obs();
    @(negedge clk); bus.rdy = 1'b0; bus.rdy_for_sn_ack = 1'b1;
    #1;
    total++;
    if (bus.rdy_ack !== 1'b0 || bus.rdy_for_sn !== 1'b0) begin
      bad++; $display("FAIL rdylow: rdy_ack=%b rdy_for_sn=%b want 0 0", bus.rdy_ack, bus.rdy_for_sn);
    end
    bus.sn_wr_en = 1'b1; bus.sn_byte_inc = 8'd4;
    repeat (4) begin bus.sn_wr_data = $urandom; @(negedge clk); end
    bus.sn_done = 1'b1; @(negedge clk);
    bus.sn_wr_en = 1'b0; bus.sn_done = 1'b0; bus.rdy_for_sn_ack = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || done_cyc.size() != 0) begin
      bad++; $display("FAIL rdylow ignored: writes=%0d done=%0d want 0 0", obs_q.size(), done_cyc.size());
    end
    run_packet("after_rdylow", 3, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      int n;
      bit dwl;
      n   = $urandom_range(1, 12);
      dwl = $urandom_range(0, 1);
      run_packet($sformatf("rand%0d", p), n, 2, dwl, 1'b0);
    end
  endtask

  initial begin
    bus.sn_wr_data = '0; bus.sn_wr_en = 1'b0; bus.sn_byte_inc = '0;
    bus.sn_done = 1'b0; bus.rdy_for_sn_ack = 1'b0; bus.rdy = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_flush();
    test_wrap();
    test_reset_mid();
    test_rdy_low();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
